imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, 64, number of 32-bit words in the target instruction memory.
REQ-002 Parameter AW, 6, word-address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  load request, sampled only in IDLE.
REQ-006 word_count  input  AW+1  number of words to load, sampled with start.
REQ-007 byte_in  input  8  program byte stream data.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 waddr  output  AW  word address of the write; byte address is waddr*4.
REQ-012 wdata  output  32  assembled instruction word.
REQ-013 busy  output  1  load in progress; processor SHALL hold its PC while high.
REQ-014 done  output  1  one-cycle pulse when the final word is written.
REQ-015 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 States: IDLE, RECV, WRITE, DONE; encoding is free.
REQ-017 IDLE: if start=1 and 1<=word_count<=DEPTH, latch word_count, clear word index and byte index, go to RECV.
REQ-018 IDLE: if start=1 and word_count is 0 or greater than DEPTH, pulse err for one cycle and stay in IDLE.
REQ-019 byte_ready SHALL be 1 only in RECV; a byte transfers on a cycle where byte_valid=1 and byte_ready=1.
REQ-020 Bytes assemble little-endian: byte index 0 goes to wdata[7:0], 1 to [15:8], 2 to [23:16], 3 to [31:24].
REQ-021 On the 4th accepted byte, go to WRITE on the next edge; byte_valid=0 cycles stall RECV indefinitely with no state change.
REQ-022 WRITE lasts exactly one cycle: we=1, waddr=word index, wdata=assembled word; byte_ready=0.
REQ-023 After WRITE: if word index = latched count-1, go to DONE; otherwise increment the word index, clear the byte index, and go to RECV.
REQ-024 DONE lasts one cycle with done=1, then the block returns to IDLE.
REQ-025 busy SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-026 start SHALL be ignored while busy=1; the load in progress is unaffected.
REQ-027 Word index never wraps: the maximum waddr is latched count-1, which is at most DEPTH-1.
REQ-028 Latency: the first we occurs 1 cycle after the 4th byte handshake; done occurs 1 cycle after the final we.
REQ-029 wdata and waddr hold their last values outside WRITE; they are only meaningful when we=1.

Reset
REQ-030 When rst_n=0 at a rising edge: state=IDLE; byte_ready, we, busy, done and err = 0; waddr=0; wdata=0; counters=0.
REQ-031 A reset asserted mid-load SHALL abort the load immediately with no further we; words already written are not undone.
REQ-032 The first start SHALL be accepted on the first edge after rst_n returns to 1.

Verification
REQ-033 Reset, then start with word_count=2 and bytes 33,70,00,00,93,00,10,00 at 1 byte/cycle: we at waddr 0 with wdata 00007033, we at waddr 1 with 00100093, then done 1 cycle later; busy falls with done.
REQ-034 start with word_count=0, and separately word_count=65: err pulse of 1 cycle each, busy stays 0, no we.
REQ-035 word_count=1 with byte_valid toggling 1,0,0,1,1,0,1: exactly 4 bytes accepted, one we, wdata matches, no extra byte_ready cycles outside RECV.
REQ-036 word_count=64 with a continuous stream: 64 we pulses, waddr 0..63 in order, done after waddr 63, no wrap to 0.
REQ-037 Reset asserted after 2 bytes of word 1: the next cycle shows busy=0 and no we; a fresh start with word_count=1 loads correctly from byte index 0.
REQ-038 start pulsed during RECV with word_count=5: ignored; the original count completes and the word sequence is unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit little-endian words and writes them to instruction memory; we one cycle after each 4th byte, done one cycle after the last we.
// Backpressure: byte_ready is high only while collecting bytes, so the producer stalls during WRITE/DONE/IDLE.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [AW:0]   i_word_count,
  input  logic [7:0]    i_byte_in,
  input  logic          i_byte_valid,
  output logic          o_byte_ready,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [31:0]   o_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  state_t        r_state;
  state_t        w_next;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_widx;
  logic [1:0]    r_bidx;
  logic [23:0]   r_asm;
  logic [AW-1:0] r_waddr;
  logic [31:0]   r_wdata;
  logic          r_err;

  logic w_count_ok;
  logic w_accept;
  logic w_last_byte;
  logic w_last_word;

  assign w_count_ok  = (i_word_count != '0) && (i_word_count <= LP_DEPTH);
  assign w_accept    = (r_state == S_RECV) && i_byte_valid;
  assign w_last_byte = w_accept && (r_bidx == 2'd3);
  // Compare in AW+1 bits so a count of DEPTH never aliases onto index 0.
  assign w_last_word = ({1'b0, r_widx} == (r_count - LP_ONE));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start && w_count_ok) w_next = S_RECV;
      S_RECV:  if (w_last_byte) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_DONE : S_RECV;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_byte_ready = (r_state == S_RECV);
    o_we         = (r_state == S_WRITE);
    o_busy       = (r_state != S_IDLE);
    o_done       = (r_state == S_DONE);
    o_waddr      = r_waddr;
    o_wdata      = r_wdata;
    o_err        = r_err;
  end

  // The output word/address are captured on the 4th byte so they stay stable
  // while the next word assembles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_widx  <= '0;
      r_bidx  <= '0;
      r_asm   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && i_start && !w_count_ok;
      case (r_state)
        S_IDLE: begin
          if (i_start && w_count_ok) begin
            r_count <= i_word_count;
            r_widx  <= '0;
            r_bidx  <= '0;
          end
        end
        S_RECV: begin
          if (w_accept) begin
            r_bidx <= r_bidx + 2'd1;
            case (r_bidx)
              2'd0:    r_asm[7:0]   <= i_byte_in;
              2'd1:    r_asm[15:8]  <= i_byte_in;
              2'd2:    r_asm[23:16] <= i_byte_in;
              default: begin
                r_wdata <= {i_byte_in, r_asm};
                r_waddr <= r_widx;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (!w_last_word) begin
            r_widx <= r_widx + AW'(1);
            r_bidx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-list scoreboard predicts every memory write and the load handshake timing.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [AW:0]   i_word_count;
  logic [7:0]    i_byte_in;
  logic          i_byte_valid;
  logic          o_byte_ready;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [31:0]   o_wdata;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_word_count (i_word_count),
    .i_byte_in    (i_byte_in),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int        n_checks = 0;
  int        n_fail   = 0;
  bit [7:0]  bytes_q[$];
  int        vpat[$];
  bit [31:0] obs_data[DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    bytes_q.delete();
    for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
  endtask

  // Runs one load of cnt words from bytes_q; pct sets byte_valid density unless vpat
  // is non-empty; inj_at >= 0 pulses a stray start (word_count=5) at that cycle.
  task automatic do_load(input int cnt, input int pct, input int inj_at);
    int        nb;
    int        consumed;
    int        writes;
    int        cyc;
    int        hs_cyc;
    int        we_cyc;
    bit        fin;
    bit        v;
    bit [31:0] exp_w;
    nb       = cnt * 4;
    consumed = 0;
    writes   = 0;
    cyc      = 0;
    hs_cyc   = -10;
    we_cyc   = -10;
    fin      = 1'b0;
    exp_w    = '0;
    chk("idle_ready", o_byte_ready, 0);
    chk("idle_busy", o_busy, 0);
    i_start      = 1'b1;
    i_word_count = (AW+1)'(cnt);
    step();
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    while (!fin && cyc < 4000) begin
      if (o_we) begin
        if (writes < cnt) begin
          exp_w = {bytes_q[4*writes+3], bytes_q[4*writes+2],
                   bytes_q[4*writes+1], bytes_q[4*writes]};
          chk("waddr", 32'(o_waddr), writes);
          chk("wdata", o_wdata, exp_w);
          chk("we_latency", cyc, hs_cyc + 1);
          chk("bytes_at_we", consumed, 4 * (writes + 1));
          obs_data[writes] = o_wdata;
        end else begin
          chk("extra_we", 1, 0);
        end
        chk("ready_in_write", o_byte_ready, 0);
        writes++;
        we_cyc = cyc;
      end
      if (o_done) begin
        chk("done_latency", cyc, we_cyc + 1);
        chk("done_words", writes, cnt);
        chk("done_busy", o_busy, 1);
        fin = 1'b1;
      end
      if (o_err) chk("err_while_busy", o_err, 0);
      if (vpat.size() > 0) v = (consumed < nb) && (vpat[cyc % vpat.size()] != 0);
      else                 v = (consumed < nb) && ($urandom_range(99) < 32'(pct));
      i_byte_valid = v;
      i_byte_in    = v ? bytes_q[consumed] : 8'($urandom);
      i_start      = (cyc == inj_at);
      i_word_count = (cyc == inj_at) ? 7'd5 : (AW+1)'(cnt);
      if (o_byte_ready && v) begin
        consumed++;
        if (consumed % 4 == 0) hs_cyc = cyc;
      end
      step();
      cyc++;
    end
    if (!fin) chk("load_timeout", 0, 1);
    i_byte_valid = 1'b0;
    i_start      = 1'b0;
    chk("busy_after_done", o_busy, 0);
    chk("ready_after_done", o_byte_ready, 0);
    chk("bytes_used", consumed, nb);
    chk("wdata_hold", o_wdata, exp_w);
  endtask

  task automatic check_err(input int cnt);
    i_start      = 1'b1;
    i_word_count = (AW+1)'(cnt);
    step();
    i_start = 1'b0;
    chk("err_pulse", o_err, 1);
    chk("err_busy", o_busy, 0);
    chk("err_we", o_we, 0);
    step();
    chk("err_one_cycle", o_err, 0);
    chk("err_busy_after", o_busy, 0);
  endtask

  initial begin
    int consumed;
    int n_we;
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_word_count = '0;
    i_byte_in    = '0;
    i_byte_valid = 1'b0;
    step();
    step();
    chk("rst_ready", o_byte_ready, 0);
    chk("rst_we", o_we, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_waddr", 32'(o_waddr), 0);
    chk("rst_wdata", o_wdata, 0);
    i_rst_n = 1'b1;

    // Two-word program from a known instruction stream.
    bytes_q = '{8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load(2, 100, -1);
    chk("w0_literal", obs_data[0], 32'h00007033);
    chk("w1_literal", obs_data[1], 32'h00100093);

    check_err(0);
    check_err(65);
    check_err(127);

    fill_rand(4);
    vpat = '{1, 0, 0, 1, 1, 0, 1};
    do_load(1, 100, -1);
    vpat.delete();

    fill_rand(4 * DEPTH);
    do_load(DEPTH, 100, -1);
    chk("last_word", obs_data[DEPTH-1],
        {bytes_q[4*DEPTH-1], bytes_q[4*DEPTH-2], bytes_q[4*DEPTH-3], bytes_q[4*DEPTH-4]});

    fill_rand(12);
    do_load(3, 100, 5);

    // Abort a load after two bytes of the second word.
    fill_rand(8);
    i_start      = 1'b1;
    i_word_count = 7'd2;
    step();
    i_start  = 1'b0;
    consumed = 0;
    n_we     = 0;
    for (int i = 0; i < 40 && consumed < 6; i++) begin
      if (o_we) n_we++;
      i_byte_valid = 1'b1;
      i_byte_in    = bytes_q[consumed];
      if (o_byte_ready) consumed++;
      step();
    end
    chk("abort_bytes", consumed, 6);
    chk("abort_we_before", n_we, 1);
    i_rst_n = 1'b0;
    step();
    chk("abort_busy", o_busy, 0);
    chk("abort_we", o_we, 0);
    chk("abort_ready", o_byte_ready, 0);
    chk("abort_waddr", 32'(o_waddr), 0);
    chk("abort_wdata", o_wdata, 0);
    i_rst_n      = 1'b1;
    i_byte_valid = 1'b0;
    fill_rand(4);
    do_load(1, 100, -1);

    for (int t = 0; t < 8; t++) begin
      int cnt;
      cnt = $urandom_range(8, 1);
      fill_rand(4 * cnt);
      do_load(cnt, $urandom_range(100, 30), (t % 2 == 1) ? $urandom_range(10, 1) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
